frame_transfer_engine: RTL and testbench
========================================

# frame_transfer_engine

Moves exactly one frame of ADC samples from the ADC FIFO into the Python-side FIFO each time the trigger FSM pulses `trigger_i`. It is the consumer end of the trigger handshake: the FSM decides *when* a frame may move, and this block *moves* it. Reads use a first-word-fall-through interface, and writes are throttled by the downstream full flag. The block reports busy, done and overrun status back to the FSM and to software.

## Interface
- `FRAME_SIZE`, 1280: words per frame. Legal range is 1 to 2047.
- `DATA_W`, 32: sample word width.
- `CNT_W`, 11: counter width. It must be at least clog2(FRAME_SIZE+1).
- `clk` input, 1 bit: single clock domain.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `trigger_i` input, 1 bit: one-cycle request to transfer a frame.
- `adc_fifo_dout_i` input, DATA_W bits: FWFT head word. Valid whenever `adc_fifo_empty_i` is 0.
- `adc_fifo_empty_i` input, 1 bit: ADC FIFO empty flag.
- `adc_fifo_rd_en_o` output, 1 bit: pop strobe. Consumes the current head word.
- `py_fifo_full_i` input, 1 bit: Python FIFO full flag.
- `py_fifo_din_o` output, DATA_W bits: write data.
- `py_fifo_wr_en_o` output, 1 bit: write strobe.
- `busy_o` output, 1 bit: high while a frame is in flight (XFER or DONE state).
- `done_o` output, 1 bit: one-cycle pulse when the final word has been written.
- `overrun_o` output, 1 bit: one-cycle pulse when a trigger is rejected because the block is busy.

## Operation
- FSM states:
  - IDLE: `trigger_i`=1 moves to XFER and clears both counters.
  - XFER: moves to DONE in the cycle after `wr_cnt` reaches FRAME_SIZE.
  - DONE: lasts one cycle, then returns unconditionally to IDLE.
- Output stage: one register, `out_data` plus an `out_valid` flag.
  - `py_fifo_wr_en_o` = `out_valid` & !`py_fifo_full_i`. This path is combinational from the full flag.
  - `py_fifo_din_o` = `out_data`.
- Read: `adc_fifo_rd_en_o` = XFER & (`rd_cnt` < FRAME_SIZE) & !`adc_fifo_empty_i` & (!`out_valid` | `py_fifo_wr_en_o`).
  - Every pop loads `adc_fifo_dout_i` into `out_data` and sets `out_valid`.
  - A write with no simultaneous pop clears `out_valid`.
- Counters: `rd_cnt` increments on each pop and `wr_cnt` on each write. Both are CNT_W bits, unsigned, and never wrap; `rd_cnt` saturates its pops at FRAME_SIZE.
- Triggers: only accepted in IDLE. A trigger seen in XFER or DONE is dropped and gives `overrun_o`=1 in the next cycle. There is no queueing.
- Stalls:
  - ADC FIFO empty: pops pause and the frame completes later. There is no timeout.
  - Python FIFO full: `out_data` holds and pops stop until space frees.
  - Empty and full in the same cycle: both rules apply independently.
- Reset asserted mid-frame: the partial frame is abandoned and all state returns to reset values. Words already written stay in the Python FIFO, and the FSM is responsible for recovery.

## Timing
- Reset values:
  - FSM in IDLE; `rd_cnt` = `wr_cnt` = 0; `out_valid` = 0; `out_data` = 0.
  - All outputs 0: `adc_fifo_rd_en_o`, `py_fifo_wr_en_o`, `busy_o`, `done_o`, `overrun_o`, and `py_fifo_din_o` = 0.
- Zero-stall frame, with the trigger at cycle N:
  - XFER begins at N+1 and `busy_o`=1 from N+1.
  - Pops occur at N+1 through N+FRAME_SIZE.
  - Writes occur at N+2 through N+FRAME_SIZE+1.
  - DONE at N+FRAME_SIZE+2, with `done_o`=1 and `busy_o`=1.
  - IDLE at N+FRAME_SIZE+3, with `busy_o`=0. A new trigger is accepted from this cycle.
- Throughput: one word per cycle sustained, with a first-word latency of 2 cycles from the trigger.
- Stall latency: each stall cycle delays `done_o` by exactly one cycle.

## Structure
- Shared package `trigger_pkg`:
  - State encoding IDLE=2'd0, XFER=2'd1, DONE=2'd2.
  - Default constants FRAME_SIZE=1280 and DATA_W=32. The trigger FSM uses the same constants.
- Sub-module `frame_out_stage`: the one-entry output register with its valid/ready logic (`out_valid`, write strobe, accept).
- Top level: contains the FSM, the two counters and the status pulses.

## Test plan
- Directed scenarios use FRAME_SIZE=8 and a bench FIFO model.
- Basic frame: ADC preloaded with 0x10 to 0x17, Python never full, trigger at cycle 0.
  - Writes 0x10 to 0x17 in order at cycles 2 to 9.
  - `done_o` at cycle 10; `busy_o` low at cycle 11.
  - Exactly 8 pops and 8 writes.
- Full backpressure: Python full for cycles 4 to 6.
  - `py_fifo_din_o` holds at 0x12 during the stall.
  - No lost or duplicated word.
  - `done_o` at cycle 13.
- ADC starvation: only 5 words present at the trigger, and 3 more arrive at cycle 20.
  - `busy_o` stays high through the starvation gap.
  - The frame completes with 8 writes, and `done_o` follows the 8th write by exactly 1 cycle.
- Overrun: trigger at 0, 5 and 10.
  - `overrun_o` at cycles 6 and 11.
  - Exactly one frame moved.
  - A trigger at cycle 11 (IDLE) starts the second frame.
- Reset mid-frame: `reset` low at cycle 5, after 3 writes.
  - All outputs go to 0 immediately.
  - After release, a trigger moves the next 8 ADC words normally.
- Counter bound: FRAME_SIZE=2047, CNT_W=11.
  - Exactly 2047 writes, with no counter wrap.
  - `done_o` at cycle 2049.

Source files
------------

// File: rtl/frame_transfer_engine_pkg.sv
// Shared types and default constants for the trigger FSM and the frame transfer engine.
package trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } xfer_state_t;

  localparam int FRAME_SIZE_DFLT = 1280;
  localparam int DATA_W_DFLT     = 32;
  localparam int CNT_W_DFLT      = 11;

endpackage

// File: rtl/frame_transfer_engine_if.sv
// FIFO-side signal bundle: FWFT ADC FIFO read port and Python FIFO write port.
interface frame_transfer_engine_if #(
  parameter int DATA_W = trigger_pkg::DATA_W_DFLT
) ();

  logic [DATA_W-1:0] adc_fifo_dout_i;
  logic              adc_fifo_empty_i;
  logic              adc_fifo_rd_en_o;
  logic              py_fifo_full_i;
  logic [DATA_W-1:0] py_fifo_din_o;
  logic              py_fifo_wr_en_o;

  modport master (
    input  adc_fifo_dout_i, adc_fifo_empty_i, py_fifo_full_i,
    output adc_fifo_rd_en_o, py_fifo_din_o, py_fifo_wr_en_o
  );

  modport slave (
    output adc_fifo_dout_i, adc_fifo_empty_i, py_fifo_full_i,
    input  adc_fifo_rd_en_o, py_fifo_din_o, py_fifo_wr_en_o
  );

endinterface

// File: rtl/frame_transfer_engine_out_stage.sv
// One-entry output register between the ADC FIFO head and the Python FIFO write port.
module frame_out_stage
  import trigger_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_pop_data,
  input  logic              i_full,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_wr_en,
  output logic              o_accept
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // A pop wins over a write: the slot is refilled in the same cycle it drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_pop) begin
      r_data  <= i_pop_data;
      r_valid <= 1'b1;
    end else if (o_wr_en) begin
      r_valid <= 1'b0;
    end
  end

  assign o_wr_en  = r_valid & ~i_full;
  assign o_accept = ~r_valid | o_wr_en;
  assign o_data   = r_data;
  assign o_valid  = r_valid;

endmodule

// File: rtl/frame_transfer_engine.sv
// Moves one FRAME_SIZE-word frame from the ADC FIFO to the Python FIFO per accepted trigger.
module frame_transfer_engine
  import trigger_pkg::*;
#(
  parameter int FRAME_SIZE = FRAME_SIZE_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trigger_i,
  frame_transfer_engine_if.master  fifo_if,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overrun_o
);

  localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_SIZE);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_SIZE - 1);

  xfer_state_t       r_state;
  xfer_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic              r_overrun;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_accept;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic              w_start;

  assign w_start = (r_state == ST_IDLE) & trigger_i;
  assign w_rd_en = (r_state == ST_XFER) & (r_rd_cnt < FRAME_CNT) &
                   ~fifo_if.adc_fifo_empty_i & w_accept;

  frame_out_stage #(.DATA_W(DATA_W)) u_out_stage (
    .clk        (clk),
    .reset      (reset),
    .i_pop      (w_rd_en),
    .i_pop_data (fifo_if.adc_fifo_dout_i),
    .i_full     (fifo_if.py_fifo_full_i),
    .o_data     (w_out_data),
    .o_valid    (w_out_valid),
    .o_wr_en    (w_wr_en),
    .o_accept   (w_accept)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DONE is entered on the edge where the final write lands, so wr_cnt reads FRAME_SIZE in DONE.
  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (trigger_i) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        busy_o = 1'b1;
        if (w_wr_en && (r_wr_cnt == FRAME_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_start) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_en) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= trigger_i & (r_state != ST_IDLE);
    end
  end

  assign overrun_o                = r_overrun;
  assign fifo_if.adc_fifo_rd_en_o = w_rd_en;
  assign fifo_if.py_fifo_wr_en_o  = w_wr_en;
  assign fifo_if.py_fifo_din_o    = w_out_data;

endmodule

// File: tb/tb_frame_transfer_engine.sv
// Directed bench: FRAME_SIZE=8 scenarios on one instance, FRAME_SIZE=2047 bound on another.
module tb_frame_transfer_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, trig_a, busy_a, done_a, ovr_a;
  logic rst_b_n, trig_b, busy_b, done_b, ovr_b;

  frame_transfer_engine_if #(.DATA_W(32)) aif ();
  frame_transfer_engine_if #(.DATA_W(32)) bif ();

  frame_transfer_engine #(.FRAME_SIZE(8), .DATA_W(32), .CNT_W(11)) dut_a (
    .clk(clk), .reset(rst_a_n), .trigger_i(trig_a), .fifo_if(aif),
    .busy_o(busy_a), .done_o(done_a), .overrun_o(ovr_a)
  );

  frame_transfer_engine #(.FRAME_SIZE(2047), .DATA_W(32), .CNT_W(11)) dut_b (
    .clk(clk), .reset(rst_b_n), .trigger_i(trig_b), .fifo_if(bif),
    .busy_o(busy_b), .done_o(done_b), .overrun_o(ovr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scenario description and recorded history for the FRAME_SIZE=8 instance
  logic [31:0] adc_q[$];
  logic [31:0] py_data[$];
  int          py_cyc[$];
  logic [63:0] trig_mask, full_mask, rst_mask;
  logic [63:0] busy_hist, done_hist, ovr_hist;
  logic [31:0] din_hist[64];
  int          arr_cycle, arr_cnt, n_pops;
  logic [31:0] arr_base;

  task automatic clear_scn();
    trig_mask = '0; full_mask = '0; rst_mask = '0;
    arr_cycle = -1; arr_cnt = 0; arr_base = '0;
    adc_q.delete();
  endtask

  task automatic reset_a();
    rst_a_n = 1'b0; trig_a = 1'b0;
    aif.adc_fifo_empty_i = 1'b1; aif.py_fifo_full_i = 1'b0; aif.adc_fifo_dout_i = '0;
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_scn(input int ncyc);
    logic do_pop;
    n_pops = 0; py_data.delete(); py_cyc.delete();
    busy_hist = '0; done_hist = '0; ovr_hist = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == arr_cycle)
        for (int k = 0; k < arr_cnt; k++) adc_q.push_back(arr_base + 32'(k));
      rst_a_n = ~rst_mask[c];
      trig_a  = trig_mask[c];
      aif.py_fifo_full_i   = full_mask[c];
      aif.adc_fifo_empty_i = (adc_q.size() == 0);
      if (adc_q.size() != 0) aif.adc_fifo_dout_i = adc_q[0];
      else                   aif.adc_fifo_dout_i = '0;
      @(negedge clk);
      busy_hist[c] = busy_a;
      done_hist[c] = done_a;
      ovr_hist[c]  = ovr_a;
      din_hist[c]  = aif.py_fifo_din_o;
      if (rst_mask[c]) begin
        chk($sformatf("rst_c%0d_rd_en", c), aif.adc_fifo_rd_en_o, 0);
        chk($sformatf("rst_c%0d_wr_en", c), aif.py_fifo_wr_en_o, 0);
        chk($sformatf("rst_c%0d_busy", c), busy_a, 0);
        chk($sformatf("rst_c%0d_din", c), aif.py_fifo_din_o, 0);
      end
      do_pop = aif.adc_fifo_rd_en_o;
      if (aif.py_fifo_wr_en_o) begin
        py_data.push_back(aif.py_fifo_din_o);
        py_cyc.push_back(c);
      end
      @(posedge clk); #1;
      if (do_pop) begin
        void'(adc_q.pop_front());
        n_pops++;
      end
    end
    trig_a = 1'b0;
    rst_a_n = 1'b1;
  endtask

  task automatic chk_writes(input string tag, input int first, input int n,
                            input logic [31:0] base_data, input int base_cyc);
    for (int i = 0; i < n; i++) begin
      if (first + i < py_data.size()) begin
        chk($sformatf("%s_d%0d", tag, i), py_data[first+i], base_data + 32'(i));
        chk($sformatf("%s_c%0d", tag, i), py_cyc[first+i], base_cyc + i);
      end else begin
        chk($sformatf("%s_missing%0d", tag, i), py_data.size(), first + n);
      end
    end
  endtask

  int          src_b, n_wr_b, bad_b, done_cyc_b, last_wr_b;

  initial begin
    // Reset state, with trigger and data presented to prove reset dominates
    rst_a_n = 1'b0; trig_a = 1'b1;
    aif.adc_fifo_empty_i = 1'b0; aif.py_fifo_full_i = 1'b0; aif.adc_fifo_dout_i = 32'hAA;
    rst_b_n = 1'b0; trig_b = 1'b0;
    bif.adc_fifo_empty_i = 1'b1; bif.py_fifo_full_i = 1'b0; bif.adc_fifo_dout_i = '0;
    #2;
    chk("reset_rd_en", aif.adc_fifo_rd_en_o, 0);
    chk("reset_wr_en", aif.py_fifo_wr_en_o, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_ovr", ovr_a, 0);
    chk("reset_din", aif.py_fifo_din_o, 0);
    @(posedge clk); #1;
    chk("reset_hold_busy", busy_a, 0);
    chk("reset_hold_rd_en", aif.adc_fifo_rd_en_o, 0);

    // Basic frame
    clear_scn();
    reset_a();
    for (int i = 0; i < 8; i++) adc_q.push_back(32'h10 + 32'(i));
    trig_mask[0] = 1'b1;
    run_scn(14);
    chk("basic_n_wr", py_data.size(), 8);
    chk_writes("basic_wr", 0, 8, 32'h10, 2);
    chk("basic_n_pop", n_pops, 8);
    chk("basic_done", done_hist[15:0], 16'h0400);
    chk("basic_busy", busy_hist[15:0], 16'h07FE);
    chk("basic_ovr", ovr_hist, 0);

    // Python FIFO full for cycles 4..6
    clear_scn();
    reset_a();
    for (int i = 0; i < 8; i++) adc_q.push_back(32'h10 + 32'(i));
    trig_mask[0] = 1'b1;
    full_mask[6:4] = 3'b111;
    run_scn(16);
    chk("bp_n_wr", py_data.size(), 8);
    chk_writes("bp_wr_a", 0, 2, 32'h10, 2);
    chk_writes("bp_wr_b", 2, 6, 32'h12, 7);
    for (int c = 4; c <= 6; c++) chk($sformatf("bp_hold_c%0d", c), din_hist[c], 32'h12);
    chk("bp_n_pop", n_pops, 8);
    chk("bp_done", done_hist, 64'h1 << 13);

    // ADC starvation: 5 words up front, 3 more at cycle 20
    clear_scn();
    reset_a();
    for (int i = 0; i < 5; i++) adc_q.push_back(32'h30 + 32'(i));
    trig_mask[0] = 1'b1;
    arr_cycle = 20; arr_cnt = 3; arr_base = 32'h35;
    run_scn(28);
    chk("starve_n_wr", py_data.size(), 8);
    chk_writes("starve_wr_a", 0, 5, 32'h30, 2);
    chk_writes("starve_wr_b", 5, 3, 32'h35, 21);
    chk("starve_busy", busy_hist, 64'h1FF_FFFE);
    chk("starve_done", done_hist, 64'h1 << 24);

    // Overrun: triggers at 0, 5, 10 rejected-or-accepted, 11 starts frame two
    clear_scn();
    reset_a();
    for (int i = 0; i < 16; i++) adc_q.push_back(32'h40 + 32'(i));
    trig_mask[0] = 1'b1; trig_mask[5] = 1'b1; trig_mask[10] = 1'b1; trig_mask[11] = 1'b1;
    run_scn(24);
    chk("ovr_pulses", ovr_hist, (64'h1 << 6) | (64'h1 << 11));
    chk("ovr_n_wr", py_data.size(), 16);
    chk_writes("ovr_wr_f1", 0, 8, 32'h40, 2);
    chk_writes("ovr_wr_f2", 8, 8, 32'h48, 13);
    chk("ovr_done", done_hist, (64'h1 << 10) | (64'h1 << 21));

    // Reset at cycle 5 mid-frame, retrigger at cycle 8
    clear_scn();
    reset_a();
    for (int i = 0; i < 16; i++) adc_q.push_back(32'h50 + 32'(i));
    trig_mask[0] = 1'b1; trig_mask[8] = 1'b1;
    rst_mask[5] = 1'b1;
    run_scn(22);
    chk("rstmid_n_wr", py_data.size(), 11);
    chk_writes("rstmid_wr_a", 0, 3, 32'h50, 2);
    chk_writes("rstmid_wr_b", 3, 8, 32'h54, 10);
    chk("rstmid_n_pop", n_pops, 12);
    chk("rstmid_done", done_hist, 64'h1 << 18);

    // Counter bound on the FRAME_SIZE=2047 instance with an endless source
    rst_b_n = 1'b1;
    bif.adc_fifo_empty_i = 1'b0;
    src_b = 0; n_wr_b = 0; bad_b = 0; done_cyc_b = -1; last_wr_b = -1;
    @(posedge clk); #1;
    for (int c = 0; c < 2056; c++) begin
      logic pop_b;
      trig_b = (c == 0);
      bif.adc_fifo_dout_i = 32'(src_b);
      @(negedge clk);
      if (bif.py_fifo_wr_en_o) begin
        if (bif.py_fifo_din_o !== 32'(n_wr_b)) bad_b++;
        n_wr_b++;
        last_wr_b = c;
      end
      if (done_b && done_cyc_b < 0) done_cyc_b = c;
      pop_b = bif.adc_fifo_rd_en_o;
      @(posedge clk); #1;
      if (pop_b) src_b++;
    end
    trig_b = 1'b0;
    chk("bound_n_wr", n_wr_b, 2047);
    chk("bound_n_pop", src_b, 2047);
    chk("bound_data_err", bad_b, 0);
    chk("bound_last_wr", last_wr_b, 2048);
    chk("bound_done", done_cyc_b, 2049);
    chk("bound_idle", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
